// File: rtl/alu_seq.sv
// alu_seq: multi-cycle ALU with a ready/start/done handshake.
//   Single-cycle ops: AND, OR, XOR, ADD, SUB, and shifts by zero.
//   Iterative ops: SLL/SRL move one bit per cycle, and MUL does one
//   unsigned shift-add step per cycle.
// Ports:
//   clk, rst_n       clock, asynchronous active-low reset
//   start            request; it is accepted when ready=1
//   a, b, sel        operands and opcode; these are latched on accept
//   ready            low only while an iterative op is running
//   done             high for one cycle when the result registers update
//   out, hi          result; for MUL this is the product {hi,out}
//   zero, overflow   result flags
module alu_seq #(
  parameter int WIDTH   = 32,
  parameter int SHAMT_W = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [2:0]       sel,
  output logic             ready,
  output logic             done,
  output logic [WIDTH-1:0] out,
  output logic [WIDTH-1:0] hi,
  output logic             zero,
  output logic             overflow
);

  localparam logic [2:0] OP_AND = 3'b000;
  localparam logic [2:0] OP_OR  = 3'b001;
  localparam logic [2:0] OP_SLL = 3'b010;
  localparam logic [2:0] OP_SRL = 3'b011;
  localparam logic [2:0] OP_ADD = 3'b100;
  localparam logic [2:0] OP_SUB = 3'b101;
  localparam logic [2:0] OP_XOR = 3'b110;
  localparam logic [2:0] OP_MUL = 3'b111;

  localparam logic [SHAMT_W:0] CNT_MUL = (SHAMT_W+1)'(WIDTH);
  localparam logic [SHAMT_W:0] CNT_ONE = (SHAMT_W+1)'(1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t             state;
  logic [2:0]         op;
  logic [WIDTH-1:0]   wa;       // shift value, or the multiplicand
  logic [WIDTH-1:0]   wb;       // multiplier, which becomes the product low word
  logic [WIDTH-1:0]   wh;       // product high-word accumulator
  logic [SHAMT_W:0]   cnt;      // remaining RUN iterations

  logic               accept;
  logic               multi;
  logic [SHAMT_W-1:0] shamt;
  logic [WIDTH-1:0]   imm_res;
  logic               imm_ovf;
  logic [WIDTH-1:0]   sh_nxt;
  logic [WIDTH:0]     mul_sum;
  logic [WIDTH-1:0]   wh_nxt;
  logic [WIDTH-1:0]   wb_nxt;

  // Signed overflow: the operands point the same way for ADD, or opposite
  // ways for SUB, and the result sign differs from the sign of a.
  function automatic logic sgn_ovf(input logic signed [WIDTH-1:0] x,
                                   input logic signed [WIDTH-1:0] y,
                                   input logic signed [WIDTH-1:0] r,
                                   input logic                    sub);
    logic same;
    same    = (x[WIDTH-1] == y[WIDTH-1]);
    sgn_ovf = (sub ? !same : same) && (r[WIDTH-1] != x[WIDTH-1]);
  endfunction

  assign ready  = (state != RUN);
  assign done   = (state == DONE);
  assign accept = start & ready;
  assign shamt  = b[SHAMT_W-1:0];
  assign multi  = (sel == OP_MUL) ||
                  (((sel == OP_SLL) || (sel == OP_SRL)) && (shamt != '0));

  // Results for ops that finish on the accept edge
  always_comb begin
    imm_res = '0;
    imm_ovf = 1'b0;
    case (sel)
      OP_AND: imm_res = a & b;
      OP_OR:  imm_res = a | b;
      OP_XOR: imm_res = a ^ b;
      OP_ADD: begin
        imm_res = a + b;
        imm_ovf = sgn_ovf(a, b, imm_res, 1'b0);
      end
      OP_SUB: begin
        imm_res = a - b;
        imm_ovf = sgn_ovf(a, b, imm_res, 1'b1);
      end
      OP_SLL, OP_SRL: imm_res = a;   // only reached with a shift amount of 0
      default: imm_res = '0;
    endcase
  end

  // One iteration step. For MUL, {wh,wb} shifts right and absorbs the partial product
  always_comb begin
    sh_nxt  = (op == OP_SLL) ? (wa << 1) : (wa >> 1);
    mul_sum = {1'b0, wh} + (wb[0] ? {1'b0, wa} : '0);
    wh_nxt  = mul_sum[WIDTH:1];
    wb_nxt  = {mul_sum[0], wb[WIDTH-1:1]};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      op       <= '0;
      wa       <= '0;
      wb       <= '0;
      wh       <= '0;
      cnt      <= '0;
      out      <= '0;
      hi       <= '0;
      zero     <= 1'b0;
      overflow <= 1'b0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (accept) begin
            op <= sel;
            if (multi) begin
              wa    <= a;
              wb    <= b;
              wh    <= '0;
              cnt   <= (sel == OP_MUL) ? CNT_MUL : {1'b0, shamt};
              state <= RUN;
            end else begin
              out      <= imm_res;
              hi       <= '0;
              zero     <= (imm_res == '0);
              overflow <= imm_ovf;
              state    <= DONE;
            end
          end else begin
            state <= IDLE;
          end
        end
        RUN: begin
          if (op == OP_MUL) begin
            wb <= wb_nxt;
            wh <= wh_nxt;
          end else begin
            wa <= sh_nxt;
          end
          cnt <= cnt - 1'b1;
          // The last step writes its result straight into the output registers
          if (cnt == CNT_ONE) begin
            if (op == OP_MUL) begin
              out  <= wb_nxt;
              hi   <= wh_nxt;
              zero <= ({wh_nxt, wb_nxt} == '0);
            end else begin
              out  <= sh_nxt;
              hi   <= '0;
              zero <= (sh_nxt == '0);
            end
            overflow <= 1'b0;
            state    <= DONE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_seq.sv
// Testbench for alu_seq. It uses directed vectors and checks them against a scoreboard.
module tb_alu_seq;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [31:0] a, b;
  logic [2:0]  sel;
  logic        ready, done, zero, overflow;
  logic [31:0] out, hi;

  alu_seq #(.WIDTH(32), .SHAMT_W(5)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .a(a), .b(b), .sel(sel),
    .ready(ready), .done(done), .out(out), .hi(hi), .zero(zero),
    .overflow(overflow)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] eout;
    logic [31:0] ehi;
    logic        ezero;
    logic        eovf;
    int          ecyc;
    string       name;
  } exp_t;

  exp_t sbq[$];
  exp_t mon_e;
  int   cyc = 0;
  int   nchk = 0;
  int   nerr = 0;
  int   nrdy;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  // Monitor: each done pulse is checked against the oldest queued expectation
  always @(negedge clk) begin
    if (rst_n && done) begin
      if (sbq.size() == 0) begin
        chk("unexpected_done", 64'd1, 64'd0);
      end else begin
        mon_e = sbq.pop_front();
        chk({mon_e.name, "_out"},   {32'd0, out},  {32'd0, mon_e.eout});
        chk({mon_e.name, "_hi"},    {32'd0, hi},   {32'd0, mon_e.ehi});
        chk({mon_e.name, "_zero"},  {63'd0, zero}, {63'd0, mon_e.ezero});
        chk({mon_e.name, "_ovf"},   {63'd0, overflow}, {63'd0, mon_e.eovf});
        chk({mon_e.name, "_cycle"}, 64'(cyc), 64'(mon_e.ecyc));
      end
    end
  end

  // Drive one op at a negedge while ready is high. The accept edge is the next
  // posedge; lat is the number of edges from accept to the one that enters DONE.
  task automatic issue(input string nm, input logic [2:0] s,
                       input logic [31:0] xa, input logic [31:0] xb,
                       input logic [31:0] eo, input logic [31:0] eh,
                       input logic ez, input logic eov, input int lat);
    exp_t e;
    int   n;
    n = 0;
    @(negedge clk);
    while (!ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!ready) chk({nm, "_ready_timeout"}, 64'd0, 64'd1);
    a = xa; b = xb; sel = s; start = 1'b1;
    e.eout = eo; e.ehi = eh; e.ezero = ez; e.eovf = eov;
    e.ecyc = cyc + 1 + lat; e.name = nm;
    sbq.push_back(e);
  endtask

  task automatic drain();
    int n;
    n = 0;
    @(negedge clk);
    start = 1'b0;
    while (sbq.size() != 0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (sbq.size() != 0) begin
      chk("drain_timeout", 64'(sbq.size()), 64'd0);
      sbq.delete();
    end
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; a = '0; b = '0; sel = '0;
    repeat (3) @(negedge clk);
    chk("rst_out",   {32'd0, out}, 64'd0);
    chk("rst_hi",    {32'd0, hi},  64'd0);
    chk("rst_flags", {61'd0, zero, overflow, done}, 64'd0);
    chk("rst_ready", {63'd0, ready}, 64'd1);
    rst_n = 1'b1;

    issue("add_2_6",    3'b100, 32'd2,        32'd6,        32'd8,        32'd0, 1'b0, 1'b0, 0); drain();
    issue("add_ovf",    3'b100, 32'h7FFFFFFF, 32'h7FFFFFFF, 32'hFFFFFFFE, 32'd0, 1'b0, 1'b1, 0); drain();
    issue("sub_0_max",  3'b101, 32'd0,        32'h7FFFFFFF, 32'h80000001, 32'd0, 1'b0, 1'b0, 0); drain();
    issue("sub_zero",   3'b101, 32'd2,        32'd2,        32'd0,        32'd0, 1'b1, 1'b0, 0); drain();
    issue("sub_neg_ovf",3'b101, 32'h80000000, 32'd1,        32'h7FFFFFFF, 32'd0, 1'b0, 1'b1, 0); drain();
    issue("and",        3'b000, 32'h000000AA, 32'h0000FFFF, 32'h000000AA, 32'd0, 1'b0, 1'b0, 0); drain();
    issue("or",         3'b001, 32'h000000AA, 32'h0000FFFF, 32'h0000FFFF, 32'd0, 1'b0, 1'b0, 0); drain();
    issue("xor",        3'b110, 32'h000000AA, 32'h0000FFFF, 32'h0000FF55, 32'd0, 1'b0, 1'b0, 0); drain();

    // SLL by 31: ready should stay low for exactly 31 cycles
    issue("sll_31", 3'b010, 32'd1, 32'd31, 32'h80000000, 32'd0, 1'b0, 1'b0, 31);
    nrdy = 0;
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < 100 && !done; i++) begin
      if (!ready) nrdy++;
      @(negedge clk);
    end
    chk("sll_busy_cycles", 64'(nrdy), 64'd31);
    drain();

    issue("srl_sh0",  3'b011, 32'h80000000, 32'h00000020, 32'h80000000, 32'd0, 1'b0, 1'b0, 0); drain();
    issue("srl_4",    3'b011, 32'h80000000, 32'hFFFFFFE4, 32'h08000000, 32'd0, 1'b0, 1'b0, 4); drain();
    issue("mul_3_5",  3'b111, 32'd3,        32'd5,        32'd15,       32'd0, 1'b0, 1'b0, 32); drain();
    issue("mul_zero", 3'b111, 32'd0,        32'h12345678, 32'd0,        32'd0, 1'b1, 1'b0, 32); drain();

    // MUL with a spurious start while it is running
    issue("mul_max", 3'b111, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000001, 32'hFFFFFFFE, 1'b0, 1'b0, 32);
    @(negedge clk);
    start = 1'b0;
    repeat (5) @(negedge clk);
    chk("mul_busy_ready", {63'd0, ready}, 64'd0);
    a = 32'd3; b = 32'd4; sel = 3'b100; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    drain();

    // Back-to-back: start stays high through the first op's DONE cycle
    issue("b2b_sub", 3'b101, 32'd5, 32'd8, 32'hFFFFFFFD, 32'd0, 1'b0, 1'b0, 0);
    issue("b2b_add", 3'b100, 32'd3, 32'd4, 32'd7,        32'd0, 1'b0, 1'b0, 0);
    drain();

    // Put nonzero results in the registers, then reset during a MUL
    issue("pre_rst_mul", 3'b111, 32'hFFFFFFFF, 32'h2, 32'hFFFFFFFE, 32'h1, 1'b0, 1'b0, 32); drain();
    issue("rst_mul", 3'b111, 32'd7, 32'd9, 32'd63, 32'd0, 1'b0, 1'b0, 32);
    @(negedge clk);
    start = 1'b0;
    repeat (9) @(negedge clk);
    rst_n = 1'b0;
    #1;
    sbq.delete();
    chk("midrst_out",   {32'd0, out}, 64'd0);
    chk("midrst_hi",    {32'd0, hi},  64'd0);
    chk("midrst_flags", {61'd0, zero, overflow, done}, 64'd0);
    chk("midrst_ready", {63'd0, ready}, 64'd1);
    @(negedge clk);
    rst_n = 1'b1;
    nrdy = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (done) nrdy++;
    end
    chk("post_rst_no_done", 64'(nrdy), 64'd0);
    chk("post_rst_out",     {32'd0, out}, 64'd0);

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1);
  end

endmodule
